// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative shift-add multiplier / restoring divider with accumulate,
// flush, defined divide-by-zero results and a last-result cache.
module muldiv_unit #(
   parameter int WIDTH    = 32,
   parameter bit CACHE_EN = 1'b1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [2:0]         op,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   input  logic [2*WIDTH-1:0] hilo_i,
   input  logic               flush,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] result
);
   localparam int            CW        = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

   state_t             state, state_nxt;
   logic [CW-1:0]      cnt;
   logic               c_vld;
   logic [2:0]         c_op, op_r;
   logic [WIDTH-1:0]   c_a, c_b, a_r, b_r, a_m, b_m, hi, lo;
   logic [2*WIDTH-1:0] hilo_r, prod_s, fin_res;
   logic               neg_q, neg_r;
   logic signed [WIDTH-1:0] a_s, b_s;
   logic [WIDTH:0]     mul_sum, rem_sh, rem_diff;
   logic               is_sgn, is_div, r_div, div_by_zero, cache_hit, accept, launch, fin_ok;

   function automatic logic [WIDTH-1:0] mag(input logic signed [WIDTH-1:0] v, input logic sgn);
      return (sgn && v < 0) ? -v : v;
   endfunction

   function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v, input logic n);
      return n ? -v : v;
   endfunction

   function automatic logic [2*WIDTH-1:0] neg_d(input logic [2*WIDTH-1:0] v, input logic n);
      return n ? -v : v;
   endfunction

   assign a_s         = a;
   assign b_s         = b;
   assign is_sgn      = ~op[0];
   assign is_div      = ~op[2] & op[1];
   assign r_div       = ~op_r[2] & op_r[1];
   assign div_by_zero = is_div && (b == '0);
   assign cache_hit   = CACHE_EN && c_vld && (op == c_op) && (a == c_a) && (b == c_b) && !op[2];
   assign accept      = start && !flush && (state == IDLE);
   assign launch      = accept && !cache_hit && !div_by_zero;
   assign fin_ok      = (state == FIN) && !flush;
   assign busy        = (state != IDLE);

   // One iteration step: {hi,lo} acts as product/multiplier or remainder/quotient
   assign mul_sum  = {1'b0, hi} + (lo[0] ? {1'b0, a_m} : '0);
   assign rem_sh   = {hi, lo[WIDTH-1]};
   assign rem_diff = rem_sh - {1'b0, b_m};

   assign prod_s = neg_d({hi, lo}, neg_q);

   always_comb begin
      fin_res = prod_s;
      if (r_div)        fin_res = {neg_w(hi, neg_r), neg_w(lo, neg_q)};
      else if (op_r[2]) fin_res = op_r[1] ? hilo_r - prod_s : hilo_r + prod_s;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (launch) state_nxt = RUN;
         RUN:     if (flush) state_nxt = IDLE;
                  else if (cnt == LAST_ITER) state_nxt = FIN;
         FIN:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt    <= '0;
         done   <= 1'b0;
         result <= '0;
         c_vld  <= 1'b0;
      end else begin
         cnt  <= (state == RUN && !flush) ? cnt + CW'(1) : '0;
         done <= 1'b0;
         if (fin_ok) begin
            done   <= 1'b1;
            result <= fin_res;
            // an accumulate result no longer matches any cached op/a/b
            c_vld  <= !op_r[2];
         end else if (accept && cache_hit) begin
            done <= 1'b1;
         end else if (accept && div_by_zero) begin
            done   <= 1'b1;
            result <= {a, {WIDTH{1'b1}}};
            c_vld  <= 1'b1;
         end
         if (flush) c_vld <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (fin_ok) begin
         c_op <= op_r;
         c_a  <= a_r;
         c_b  <= b_r;
      end else if (accept && !cache_hit && div_by_zero) begin
         c_op <= op;
         c_a  <= a;
         c_b  <= b;
      end

      if (launch) begin
         op_r   <= op;
         a_r    <= a;
         b_r    <= b;
         hilo_r <= hilo_i;
         a_m    <= mag(a_s, is_sgn);
         b_m    <= mag(b_s, is_sgn);
         neg_q  <= is_sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
         neg_r  <= is_sgn & a[WIDTH-1];
         hi     <= '0;
         lo     <= is_div ? mag(a_s, is_sgn) : mag(b_s, is_sgn);
      end else if (state == RUN) begin
         if (r_div) begin
            hi <= rem_diff[WIDTH] ? rem_sh[WIDTH-1:0] : rem_diff[WIDTH-1:0];
            lo <= {lo[WIDTH-2:0], ~rem_diff[WIDTH]};
         end else begin
            hi <= mul_sum[WIDTH:1];
            lo <= {mul_sum[0], lo[WIDTH-1:1]};
         end
      end
   end
endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed vectors push expected result and done edge,
// a negedge monitor pops and compares on every done pulse.
module tb_muldiv_unit;
   localparam int W = 32;
   localparam logic [2*W-1:0] R_100_7 = 64'h00000002_0000000E;

   logic           clk = 1'b0, rst = 1'b0, start = 1'b0, nc_start = 1'b0, flush = 1'b0;
   logic [2:0]     op = '0;
   logic [W-1:0]   a = '0, b = '0;
   logic [2*W-1:0] hilo = '0;
   logic           busy, done, nc_busy, nc_done;
   logic [2*W-1:0] result, nc_result;
   int             n_vec = 0, n_err = 0, cyc = 0;

   typedef struct {
      logic [2*W-1:0] res;
      int             edge_no;
      string          name;
   } exp_t;
   exp_t sb[$];

   muldiv_unit #(.WIDTH(W), .CACHE_EN(1'b1)) u_dut (
      .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .hilo_i(hilo),
      .flush(flush), .busy(busy), .done(done), .result(result));

   muldiv_unit #(.WIDTH(W), .CACHE_EN(1'b0)) u_nc (
      .clk(clk), .rst(rst), .start(nc_start), .op(op), .a(a), .b(b), .hilo_i(hilo),
      .flush(flush), .busy(nc_busy), .done(nc_done), .result(nc_result));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %h, required %h", name, act, req);
      end
   endtask

   task automatic expect_done(input string name, input logic [2*W-1:0] res, input int edge_no);
      exp_t e;
      e.res = res;
      e.edge_no = edge_no;
      e.name = name;
      sb.push_back(e);
   endtask

   // Called just after an edge; lat = edges from the accept edge to the done edge.
   task automatic issue(input string name, input logic [2:0] o, input logic [W-1:0] aa,
                        input logic [W-1:0] bb, input logic [2*W-1:0] h,
                        input logic [2*W-1:0] res, input int lat);
      op = o; a = aa; b = bb; hilo = h; start = 1'b1;
      expect_done(name, res, cyc + 1 + lat);
      @(posedge clk); #1 start = 1'b0;
      check({name, "_busy"}, 64'(busy), (lat == 0) ? 64'd0 : 64'd1);
   endtask

   task automatic wait_idle(input string name);
      int i = 0;
      while (busy === 1'b1 && i < 80) begin
         @(posedge clk); #1;
         i++;
      end
      check({name, "_finished"}, 64'(busy), 64'd0);
      @(posedge clk); #1;
   endtask

   initial forever begin
      @(negedge clk);
      if (done === 1'b1) begin
         if (sb.size() == 0) begin
            check("unexpected_done", 64'(done), 64'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check({e.name, "_res"}, result, e.res);
            check({e.name, "_edge"}, 64'(cyc), 64'(e.edge_no));
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1);
   end

   initial begin
      int d0, d1, d2, i;
      #12;
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_result", result, 64'd0);
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1;

      issue("mult", 3'b000, 32'hFFFFFFFE, 32'd3, '0, 64'hFFFFFFFF_FFFFFFFA, 33); wait_idle("mult");
      issue("multu", 3'b001, 32'hFFFFFFFE, 32'd3, '0, 64'h00000002_FFFFFFFA, 33); wait_idle("multu");
      issue("div_neg", 3'b010, 32'hFFFFFFF9, 32'd2, '0, 64'hFFFFFFFF_FFFFFFFD, 33); wait_idle("div_neg");
      issue("div_min", 3'b010, 32'h80000000, 32'hFFFFFFFF, '0, 64'h00000000_80000000, 33);
      wait_idle("div_min");
      issue("divu_zero", 3'b011, 32'd7, 32'd0, '0, 64'h00000007_FFFFFFFF, 0); wait_idle("divu_zero");
      issue("msub", 3'b110, 32'd3, 32'd5, 64'h10, 64'h1, 33); wait_idle("msub");
      issue("maddu_wrap", 3'b101, 32'd1, 32'd1, 64'hFFFFFFFF_FFFFFFFF, 64'h0, 33);
      wait_idle("maddu_wrap");

      // Held start: full operation, then a cache hit on the following edge
      op = 3'b011; a = 32'd100; b = 32'd7; hilo = '0; start = 1'b1;
      expect_done("divu_first", R_100_7, cyc + 1 + 33);
      i = 0;
      do begin
         @(posedge clk); #1;
         i++;
      end while (done !== 1'b1 && i < 80);
      expect_done("divu_held_hit", R_100_7, cyc + 1);
      @(posedge clk); #1 start = 1'b0;
      check("divu_held_hit_busy", 64'(busy), 64'd0);
      @(posedge clk); #1;

      issue("divu_hit", 3'b011, 32'd100, 32'd7, '0, R_100_7, 0); wait_idle("divu_hit");

      // Same held-start sequence without a cache: both starts run in full
      op = 3'b011; a = 32'd100; b = 32'd7; nc_start = 1'b1;
      d0 = cyc + 1; d1 = -1; d2 = -1;
      for (int k = 0; k < 100 && d2 < 0; k++) begin
         @(posedge clk); #1;
         if (nc_done === 1'b1) begin
            if (d1 < 0) begin
               d1 = cyc;
               check("nc_first_res", nc_result, R_100_7);
            end else begin
               d2 = cyc;
            end
         end
      end
      nc_start = 1'b0;
      check("nc_second_res", nc_result, R_100_7);
      check("nc_first_latency", 64'(d1 - d0), 64'd33);
      check("nc_reaccept_latency", 64'(d2 - d1 - 1), 64'd33);
      @(posedge clk); #1;

      // Flush during iteration 10 of a signed divide
      op = 3'b010; a = 32'd100; b = 32'd7; start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      repeat (9) @(posedge clk);
      #1 flush = 1'b1;
      @(posedge clk); #1 flush = 1'b0;
      check("flush_busy", 64'(busy), 64'd0);
      check("flush_done", 64'(done), 64'd0);
      repeat (40) @(posedge clk);
      #1;
      check("flush_result", result, R_100_7);

      issue("divu_after_flush", 3'b011, 32'd100, 32'd7, '0, R_100_7, 33); wait_idle("divu_after_flush");

      // start together with flush is ignored, even for a divide by zero
      op = 3'b011; a = 32'd7; b = 32'd0; start = 1'b1; flush = 1'b1;
      @(posedge clk); #1 start = 1'b0; flush = 1'b0;
      check("flush_start_busy", 64'(busy), 64'd0);
      check("flush_start_done", 64'(done), 64'd0);
      @(posedge clk); #1;
      check("flush_start_result", result, R_100_7);

      // Asynchronous reset in the middle of a multiply
      op = 3'b000; a = 32'd5; b = 32'd6; start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      repeat (5) @(posedge clk);
      #3 rst = 1'b0;
      #1;
      check("arst_busy", 64'(busy), 64'd0);
      check("arst_result", result, 64'd0);
      @(posedge clk); #1 rst = 1'b1;
      repeat (40) @(posedge clk);
      #1;
      check("arst_idle_busy", 64'(busy), 64'd0);
      check("arst_idle_result", result, 64'd0);

      check("scoreboard_drained", 64'(sb.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
